// File: rtl/axis_rx_packet_buffer_pkg.sv
// Shared types and helpers for the AXI-Stream receive packet buffer.
// The DROP state and the strobe check are common to the buffer and its neighbours.
package axis_rx_packet_buffer_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    localparam int DEFAULT_PKT_LEN = 256;

    // True when the low nbytes strobe bits are all set; bits above nbytes are ignored.
    function automatic logic strb_all_ones(input logic [127:0] strb, input int nbytes);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if (i < nbytes && !strb[i]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/axis_rx_packet_buffer_if.sv
// AXI-Stream beat channel between the upstream source and the packet buffer.
// The master modport drives data/valid/strobe/last, the slave modport drives ready.
interface axis_rx_packet_buffer_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic                    tvalid;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata,
        output tvalid,
        output tstrb,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tstrb,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_rx_packet_buffer_sdp_ram.sv
// Simple dual-port storage for {last, data} beats: one write and one registered read per cycle.
// Only the read register is reset so the array itself still maps onto block RAM.
module axis_rx_packet_buffer_sdp_ram #(
    parameter  int WIDTH  = 33,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_rx_packet_buffer.sv
// Store-and-forward AXI-Stream sink: only packets whose TLAST has arrived become readable.
// Packets that cannot fit in the buffer are discarded and flagged with a one-cycle pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | beats are written; TREADY follows buffer space
// ST_DROP | oversize packet in flight; beats accepted and discarded until TLAST
module axis_rx_packet_buffer
    import axis_rx_packet_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int PKT_LEN    = DEFAULT_PKT_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    axis_rx_packet_buffer_if.slave  s_axis,
    input  logic                    i_rd_en,
    output logic [DATA_WIDTH-1:0]   o_dout,
    output logic                    o_dout_last,
    output logic                    o_dout_valid,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_pkt_cnt,
    output logic                    o_len_err,
    output logic                    o_strb_err,
    output logic                    o_ovf_drop
);

    localparam int              ADDR_W  = $clog2(DEPTH);
    localparam int              STRB_W  = DATA_WIDTH / 8;
    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    state_t            r_state;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_commit_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_beat_cnt;
    logic [ADDR_W:0]   r_pkt_cnt;
    logic              r_out_en;
    logic              r_dout_valid;
    logic              r_len_err;
    logic              r_strb_err;
    logic              r_ovf_drop;
    logic [DEPTH-1:0]  r_last_flags;

    logic [ADDR_W:0]   w_used;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf;
    logic              w_tready;
    logic              w_accept;
    logic              w_wr;
    logic              w_commit;
    logic              w_rd;
    logic              w_rd_last;
    logic              w_strb_ok;
    logic [DATA_WIDTH:0] w_rdata;

    assign w_used    = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_used == DEPTH_P);
    assign w_empty   = (r_rd_ptr == r_commit_ptr);
    // Full with no complete packet held: nothing can ever drain, so the packet is dropped.
    assign w_ovf     = (r_state == ST_RUN) && w_full && (r_pkt_cnt == '0);
    assign w_tready  = r_out_en && ((r_state == ST_DROP) || !w_full || w_ovf);
    assign w_accept  = s_axis.tvalid && w_tready;
    assign w_wr      = w_accept && (r_state == ST_RUN) && !w_ovf;
    assign w_commit  = w_wr && s_axis.tlast;
    assign w_rd      = i_rd_en && !w_empty;
    // A shadow copy of the last flags lets pkt_cnt drop on the same edge that pops the beat.
    assign w_rd_last = w_rd && r_last_flags[r_rd_ptr[ADDR_W-1:0]];
    assign w_strb_ok = strb_all_ones(128'(s_axis.tstrb), STRB_W);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_last_flags[r_wr_ptr[ADDR_W-1:0]] <= s_axis.tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_pkt_cnt    <= '0;
            r_out_en     <= 1'b0;
            r_dout_valid <= 1'b0;
            r_len_err    <= 1'b0;
            r_strb_err   <= 1'b0;
            r_ovf_drop   <= 1'b0;
        end else begin
            r_out_en     <= 1'b1;
            r_ovf_drop   <= 1'b0;
            r_dout_valid <= w_rd;
            r_pkt_cnt    <= r_pkt_cnt + {{ADDR_W{1'b0}}, w_commit}
                                      - {{ADDR_W{1'b0}}, w_rd_last};
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + ONE;
            end
            if (w_accept && (r_state == ST_RUN) && !w_strb_ok) begin
                r_strb_err <= 1'b1;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_ovf) begin
                        r_wr_ptr <= r_commit_ptr;
                        if (w_accept && s_axis.tlast) begin
                            r_ovf_drop <= 1'b1;
                            r_beat_cnt <= '0;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end else if (w_wr) begin
                        r_wr_ptr <= r_wr_ptr + ONE;
                        if (s_axis.tlast) begin
                            r_commit_ptr <= r_wr_ptr + ONE;
                            r_beat_cnt   <= '0;
                            if (32'(r_beat_cnt) + 32'd1 != 32'(PKT_LEN)) begin
                                r_len_err <= 1'b1;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + ONE;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_accept && s_axis.tlast) begin
                        r_ovf_drop <= 1'b1;
                        r_beat_cnt <= '0;
                        r_state    <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    axis_rx_packet_buffer_sdp_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata ({s_axis.tlast, s_axis.tdata}),
        .i_re    (w_rd),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    assign s_axis.tready = w_tready;
    assign o_dout        = w_rdata[DATA_WIDTH-1:0];
    assign o_dout_last   = w_rdata[DATA_WIDTH];
    assign o_dout_valid  = r_dout_valid;
    assign o_empty       = w_empty;
    assign o_pkt_cnt     = r_pkt_cnt;
    assign o_len_err     = r_len_err;
    assign o_strb_err    = r_strb_err;
    assign o_ovf_drop    = r_ovf_drop;

endmodule

// File: tb/tb_axis_rx_packet_buffer.sv
// Directed bench for the packet buffer: a 1024-deep instance and a 16-deep instance.
// Every stored beat is queued when driven and compared when it appears on dout.
module tb_axis_rx_packet_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    axis_rx_packet_buffer_if #(.DATA_WIDTH(32)) s0 ();
    axis_rx_packet_buffer_if #(.DATA_WIDTH(32)) s1 ();

    logic        rd0, rd1;
    logic [31:0] dout0, dout1;
    logic        last0, last1, dv0, dv1, empty0, empty1;
    logic [10:0] pc0;
    logic [4:0]  pc1;
    logic        le0, le1, se0, se1, ovf0, ovf1;

    axis_rx_packet_buffer u0 (
        .clk(clk), .rst(rst), .s_axis(s0), .i_rd_en(rd0),
        .o_dout(dout0), .o_dout_last(last0), .o_dout_valid(dv0), .o_empty(empty0),
        .o_pkt_cnt(pc0), .o_len_err(le0), .o_strb_err(se0), .o_ovf_drop(ovf0)
    );

    axis_rx_packet_buffer #(.DEPTH(16)) u1 (
        .clk(clk), .rst(rst), .s_axis(s1), .i_rd_en(rd1),
        .o_dout(dout1), .o_dout_last(last1), .o_dout_valid(dv1), .o_empty(empty1),
        .o_pkt_cnt(pc1), .o_len_err(le1), .o_strb_err(se1), .o_ovf_drop(ovf1)
    );

    int errors = 0;
    int checks = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [32:0] e;
        @(posedge clk);
        #1;
        if (dv0) begin
            chk("sb0_beat_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("sb0_beat", {31'b0, last0, dout0}, 64'(e));
            end
        end
        if (dv1) begin
            chk("sb1_beat_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("sb1_beat", {31'b0, last1, dout1}, 64'(e));
            end
        end
    endtask

    task automatic drive(input int inst, input logic v, input logic [31:0] d,
                         input logic l, input logic [3:0] sb);
        if (inst == 0) begin
            s0.tvalid = v; s0.tdata = d; s0.tlast = l; s0.tstrb = sb;
        end else begin
            s1.tvalid = v; s1.tdata = d; s1.tlast = l; s1.tstrb = sb;
        end
    endtask

    task automatic send(input int inst, input logic [31:0] d, input logic l,
                        input logic [3:0] sb, input logic store);
        logic acc;
        acc = 1'b0;
        drive(inst, 1'b1, d, l, sb);
        for (int k = 0; k < 64 && !acc; k++) begin
            acc = (inst == 0) ? s0.tready : s1.tready;
            if (acc && store) begin
                if (inst == 0) q0.push_back({l, d});
                else           q1.push_back({l, d});
            end
            tick();
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        drive(inst, 1'b0, 32'd0, 1'b0, 4'hF);
    endtask

    task automatic read_n(input int inst, input int n);
        if (inst == 0) rd0 = 1'b1; else rd1 = 1'b1;
        for (int k = 0; k < n; k++) tick();
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    task automatic check_reset0(input string tag);
        chk({tag, "_tready"},  64'(s0.tready), 64'd0);
        chk({tag, "_dout"},    64'(dout0),     64'd0);
        chk({tag, "_last"},    64'(last0),     64'd0);
        chk({tag, "_valid"},   64'(dv0),       64'd0);
        chk({tag, "_empty"},   64'(empty0),    64'd1);
        chk({tag, "_pkt_cnt"}, 64'(pc0),       64'd0);
        chk({tag, "_len_err"}, 64'(le0),       64'd0);
        chk({tag, "_strb_err"},64'(se0),       64'd0);
        chk({tag, "_ovf"},     64'(ovf0),      64'd0);
    endtask

    initial begin
        rst = 1'b1;
        rd0 = 1'b0;
        rd1 = 1'b0;
        drive(0, 1'b0, 32'd0, 1'b0, 4'hF);
        drive(1, 1'b0, 32'd0, 1'b0, 4'hF);
        tick();
        tick();
        check_reset0("reset");
        chk("reset_empty1", 64'(empty1), 64'd1);
        rst = 1'b0;
        tick();
        tick();
        chk("post_reset_tready", 64'(s0.tready), 64'd1);

        // Three full-length packets, then drain in order.
        for (int i = 0; i < 768; i++) begin
            send(0, 32'(i), (i % 256) == 255, 4'hF, 1'b1);
        end
        chk("t1_pkt_cnt", 64'(pc0),    64'd3);
        chk("t1_empty",   64'(empty0), 64'd0);
        chk("t1_len_err", 64'(le0),    64'd0);
        read_n(0, 768);
        chk("t1_drained",   64'(q0.size()), 64'd0);
        chk("t1_empty_end", 64'(empty0),    64'd1);
        chk("t1_pkt_end",   64'(pc0),       64'd0);

        // Open packet stays invisible until its TLAST is accepted.
        for (int i = 0; i < 100; i++) begin
            send(0, 32'(1000 + i), 1'b0, 4'hF, 1'b1);
            chk("t2_empty_open", 64'(empty0), 64'd1);
        end
        send(0, 32'd1100, 1'b1, 4'hF, 1'b1);
        chk("t2_empty_closed", 64'(empty0), 64'd0);
        chk("t2_len_err",      64'(le0),    64'd1);
        read_n(0, 101);
        chk("t2_drained", 64'(q0.size()), 64'd0);

        // Oversize packet on the 16-deep instance is dropped with TREADY held high.
        for (int i = 0; i < 20; i++) begin
            chk("t3_tready", 64'(s1.tready), 64'd1);
            send(1, 32'(2000 + i), i == 19, 4'hF, 1'b0);
        end
        chk("t3_ovf_pulse", 64'(ovf1), 64'd1);
        tick();
        chk("t3_ovf_clear", 64'(ovf1),   64'd0);
        chk("t3_pkt_cnt",   64'(pc1),    64'd0);
        chk("t3_empty",     64'(empty1), 64'd1);
        chk("t3_len_err0",  64'(le1),    64'd0);
        for (int i = 0; i < 8; i++) begin
            send(1, 32'(2100 + i), i == 7, 4'hF, 1'b1);
        end
        chk("t3_pkt_cnt8", 64'(pc1), 64'd1);
        chk("t3_len_err1", 64'(le1), 64'd1);
        read_n(1, 8);
        chk("t3_drained", 64'(q1.size()), 64'd0);

        // Fill 16 entries with two packets; a single read reopens TREADY.
        for (int i = 0; i < 16; i++) begin
            send(1, 32'(3000 + i), (i % 8) == 7, 4'hF, 1'b1);
        end
        chk("t4_tready_full", 64'(s1.tready), 64'd0);
        chk("t4_pkt_cnt",     64'(pc1),       64'd2);
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        chk("t4_dout_valid",   64'(dv1),       64'd1);
        chk("t4_tready_freed", 64'(s1.tready), 64'd1);
        read_n(1, 15);
        chk("t4_drained", 64'(q1.size()), 64'd0);
        chk("t4_pkt_end", 64'(pc1),       64'd0);

        // Last beat of A read in the same cycle B commits.
        for (int i = 0; i < 4; i++) send(0, 32'(4000 + i), i == 3, 4'hF, 1'b1);
        read_n(0, 3);
        for (int i = 0; i < 3; i++) send(0, 32'(4100 + i), 1'b0, 4'hF, 1'b1);
        chk("t5_pkt_before", 64'(pc0), 64'd1);
        drive(0, 1'b1, 32'd4103, 1'b1, 4'hF);
        rd0 = 1'b1;
        chk("t5_tready", 64'(s0.tready), 64'd1);
        q0.push_back({1'b1, 32'd4103});
        tick();
        rd0 = 1'b0;
        drive(0, 1'b0, 32'd0, 1'b0, 4'hF);
        chk("t5_pkt_after", 64'(pc0), 64'd1);
        read_n(0, 4);
        chk("t5_pkt_end", 64'(pc0),       64'd0);
        chk("t5_drained", 64'(q0.size()), 64'd0);

        // Bad strobe is sticky; reset mid-packet clears everything.
        send(0, 32'd5000, 1'b0, 4'b0111, 1'b1);
        chk("t6_strb_err", 64'(se0), 64'd1);
        send(0, 32'd5001, 1'b0, 4'hF, 1'b1);
        tick();
        chk("t6_strb_held", 64'(se0), 64'd1);
        drive(0, 1'b1, 32'd5002, 1'b0, 4'hF);
        rst = 1'b1;
        tick();
        check_reset0("t6_reset");
        q0.delete();
        q1.delete();
        drive(0, 1'b0, 32'd0, 1'b0, 4'hF);
        rst = 1'b0;
        tick();
        tick();
        chk("t6_tready_back",  64'(s0.tready), 64'd1);
        chk("t6_empty_after",  64'(empty0),    64'd1);
        chk("t6_pkt_after",    64'(pc0),       64'd0);

        tick();
        chk("end_q0", 64'(q0.size()), 64'd0);
        chk("end_q1", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
